// File: rtl/xor_hash_pkg.sv
// Shared definitions for the XOR hash row datapath: op codes, default widths
// and an elaboration-time ceil(log2) helper.
package xor_hash_pkg;

  localparam logic [1:0] OPT_NOP        = 2'b00;
  localparam int         DEF_DATA_WIDTH = 64;
  localparam int         DEF_KEY_WIDTH  = 32;

  // Smallest n such that 2**n >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/xor_out_fifo.sv
// Synchronous FIFO with registered head outputs, occupancy count, registered
// almost_full and a sticky overflow flag. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped.
module xor_out_fifo
  import xor_hash_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             almost_full,
  output logic             overflow
);

  localparam int             AW       = clog2(DEPTH);
  localparam int             CW       = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]  AF_LEVEL = CW'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             almost_full_q, almost_full_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  // Next-state: pointer/count update and the head value visible next cycle.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    do_pop        = head_valid_q & pop_ready;
    do_push       = push_valid & ((count_q != DEPTH_C) | do_pop);
    wr_ptr_d      = wr_ptr_q + AW'(do_push);
    rd_ptr_d      = rd_ptr_q + AW'(do_pop);
    count_d       = count_q + CW'(do_push) - CW'(do_pop);
    overflow_d    = overflow_q | (push_valid & ~do_push);
    almost_full_d = (count_d >= AF_LEVEL);
    head_valid_d  = (count_d != '0);
    head_data_d   = head_data_q;
    // The pushed word becomes the head when nothing older remains after the pop.
    if (do_push && (count_q == CW'(do_pop))) begin
      head_data_d = push_data;
    end else if (count_d != '0) begin
      head_data_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; validity lives in count_q,
    // so clearing it would only add reset fan-out to a RAM-like structure.
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Control and head registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_valid_q  <= 1'b0;
      head_data_q   <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      head_valid_q  <= head_valid_d;
      head_data_q   <= head_data_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign head_valid  = head_valid_q;
  assign head_data   = head_data_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

endmodule

// File: rtl/row_xor_reduce_out.sv
// Per-lane XOR reduction across all rows through a registered pairwise tree,
// followed by an output FIFO holding only non-NOP results.
// Optional feature macro: XOR_FP_MATCH_EN adds FP_WIDTH and out_hit, a per-lane
// fingerprint match of the result low bits against the key low bits.
module row_xor_reduce_out
  import xor_hash_pkg::*;
#(
  parameter int NUM_MUL    = 4,
  parameter int NUM_WR     = 8,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 6
`ifdef XOR_FP_MATCH_EN
  ,
  parameter int FP_WIDTH   = 16
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [KEY_WIDTH-1:0]                 rd_key_in,
  input  logic [1:0]                           rd_opt_in,
  input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0] rd_data_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [KEY_WIDTH-1:0]                 out_key,
  output logic [1:0]                           out_opt,
  output logic [NUM_MUL*DATA_WIDTH-1:0]        out_data,
  output logic                                 almost_full,
  output logic                                 overflow
`ifdef XOR_FP_MATCH_EN
  ,
  output logic [NUM_MUL-1:0]                   out_hit
`endif
);

  localparam int LVL    = clog2(NUM_WR);
  localparam int NP     = 1 << LVL;           // rows padded to a power of two
  localparam int LANE_W = NUM_MUL * DATA_WIDTH;
`ifdef XOR_FP_MATCH_EN
  localparam int HIT_W  = NUM_MUL;
`else
  localparam int HIT_W  = 0;
`endif
  localparam int PAYLOAD_W = KEY_WIDTH + 2 + LANE_W + HIT_W;

  // Level l holds NP>>l live words; the rest of each level is tied to zero.
  logic [LANE_W-1:0]    tree_d [LVL+1][NP];
  logic [LANE_W-1:0]    tree_q [LVL+1][NP];
  logic [KEY_WIDTH-1:0] key_d  [LVL+1];
  logic [KEY_WIDTH-1:0] key_q  [LVL+1];
  logic [1:0]           opt_d  [LVL+1];
  logic [1:0]           opt_q  [LVL+1];

  logic                 push_valid;
  logic [PAYLOAD_W-1:0] push_payload;
  logic [PAYLOAD_W-1:0] head_payload;

  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    if (l == 0) begin : g_stage0
      // Capture the row words; missing rows of a non-power-of-two count read as zero.
      always_comb begin
        key_d[0] = rd_key_in;
        opt_d[0] = rd_opt_in;
        for (int j = 0; j < NP; j++) tree_d[0][j] = '0;
        for (int i = 0; i < NUM_WR; i++) tree_d[0][i] = rd_data_in[i*LANE_W +: LANE_W];
      end
    end else begin : g_xor
      // XOR adjacent pairs of the previous level; key and opt ride alongside.
      always_comb begin
        key_d[l] = key_q[l-1];
        opt_d[l] = opt_q[l-1];
        for (int j = 0; j < NP; j++) tree_d[l][j] = '0;
        for (int j = 0; j < (NP >> l); j++) begin
          tree_d[l][j] = tree_q[l-1][2*j] ^ tree_q[l-1][2*j+1];
        end
      end
    end

    // Level register; only opt is reset since it alone marks a word as live.
    always_ff @(posedge clk) begin
      key_q[l] <= key_d[l];
      for (int j = 0; j < NP; j++) tree_q[l][j] <= tree_d[l][j];
      if (reset) opt_q[l] <= OPT_NOP;
      else       opt_q[l] <= opt_d[l];
    end
  end

`ifdef XOR_FP_MATCH_EN
  logic [NUM_MUL-1:0] hit_d, hit_q;

  // Fingerprint compare on the word entering the final tree register.
  always_comb begin
    hit_d = '0;
    for (int m = 0; m < NUM_MUL; m++) begin
      hit_d[m] = (tree_d[LVL][0][m*DATA_WIDTH +: FP_WIDTH] == key_d[LVL][FP_WIDTH-1:0]);
    end
  end

  // Match flags travel with the final tree stage.
  always_ff @(posedge clk) begin
    if (reset) hit_q <= '0;
    else       hit_q <= hit_d;
  end

  assign push_payload = {key_q[LVL], opt_q[LVL], tree_q[LVL][0], hit_q};
  assign out_hit      = head_payload[NUM_MUL-1:0];
`else
  assign push_payload = {key_q[LVL], opt_q[LVL], tree_q[LVL][0]};
`endif

  assign push_valid = (opt_q[LVL] != OPT_NOP);

  xor_out_fifo #(
    .WIDTH     (PAYLOAD_W),
    .DEPTH     (FIFO_DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_data   (push_payload),
    .pop_ready   (out_ready),
    .head_valid  (out_valid),
    .head_data   (head_payload),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  assign out_data = head_payload[HIT_W +: LANE_W];
  assign out_opt  = head_payload[HIT_W + LANE_W +: 2];
  assign out_key  = head_payload[PAYLOAD_W-1 -: KEY_WIDTH];

endmodule

// File: tb/tb_row_xor_reduce_out.sv
// Self-checking bench for row_xor_reduce_out: directed and randomized stimulus,
// a transaction-level reference model and a decoupled scoreboard monitor.
module tb_row_xor_reduce_out;

  localparam int NUM_MUL   = 4;
  localparam int NUM_WR    = 8;
  localparam int DW        = 64;
  localparam int KW        = 32;
  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 6;
  localparam int FP_WIDTH  = 16;
  localparam int LANE_W    = NUM_MUL * DW;
  localparam int IN_W      = NUM_WR * LANE_W;
  localparam int LAT       = 4;                  // 1 + log2(NUM_WR) register stages before the FIFO
  localparam int AF_LEVEL  = DEPTH - AF_MARGIN;

  typedef struct {
    logic [KW-1:0]      key;
    logic [1:0]         opt;
    logic [LANE_W-1:0]  data;
    logic [NUM_MUL-1:0] hit;
  } res_t;

  logic              clk;
  logic              reset;
  logic [KW-1:0]     rd_key_in;
  logic [1:0]        rd_opt_in;
  logic [IN_W-1:0]   rd_data_in;
  logic              out_valid;
  logic              out_ready;
  logic [KW-1:0]     out_key;
  logic [1:0]        out_opt;
  logic [LANE_W-1:0] out_data;
  logic              almost_full;
  logic              overflow;
`ifdef XOR_FP_MATCH_EN
  logic [NUM_MUL-1:0] out_hit;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_pops = 0;
  bit   mon_en = 0;
  res_t sb[$];
  res_t pipe[$];
  int   model_cnt = 0;
  bit   model_ovf = 0;

  row_xor_reduce_out dut (
    .clk         (clk),
    .reset       (reset),
    .rd_key_in   (rd_key_in),
    .rd_opt_in   (rd_opt_in),
    .rd_data_in  (rd_data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_key     (out_key),
    .out_opt     (out_opt),
    .out_data    (out_data),
    .almost_full (almost_full),
    .overflow    (overflow)
`ifdef XOR_FP_MATCH_EN
    ,
    .out_hit     (out_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: lane m is the XOR of every row's lane-m word.
  function automatic res_t reduce(input logic [KW-1:0] key, input logic [1:0] opt,
                                  input logic [IN_W-1:0] rows);
    res_t r;
    r.key  = key;
    r.opt  = opt;
    r.data = '0;
    for (int m = 0; m < NUM_MUL; m++)
      for (int i = 0; i < NUM_WR; i++)
        r.data[m*DW +: DW] ^= rows[(i*NUM_MUL + m)*DW +: DW];
    for (int m = 0; m < NUM_MUL; m++)
      r.hit[m] = (r.data[m*DW +: FP_WIDTH] == key[FP_WIDTH-1:0]);
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_rows();
    logic [IN_W-1:0] v;
    for (int i = 0; i < IN_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge pass, then advance the model.
  task automatic tick(input logic [KW-1:0] key, input logic [1:0] opt,
                      input logic [IN_W-1:0] rows, input bit ready, input bit rst);
    res_t r, arr, nop;
    bit   pop;
    rd_key_in  = key;
    rd_opt_in  = opt;
    rd_data_in = rows;
    out_ready  = ready;
    reset      = rst;
    r = reduce(key, opt, rows);
    @(posedge clk);
    #1;
    if (rst) begin
      nop = reduce('0, 2'b00, '0);
      pipe.delete();
      for (int k = 0; k < LAT; k++) pipe.push_back(nop);
      sb.delete();
      model_cnt = 0;
      model_ovf = 0;
    end else begin
      pop = (model_cnt > 0) && ready;
      pipe.push_back(r);
      arr = pipe.pop_front();
      if (pop) model_cnt--;
      if (arr.opt != 2'b00) begin
        if (model_cnt < DEPTH) begin
          sb.push_back(arr);
          model_cnt++;
        end else begin
          model_ovf = 1;
        end
      end
    end
  endtask

  task automatic nop_tick(input bit ready);
    tick($urandom, 2'b00, rand_rows(), ready, 1'b0);
  endtask

  task automatic op_tick(input bit ready);
    tick($urandom, 2'($urandom_range(1, 3)), rand_rows(), ready, 1'b0);
  endtask

  // Flush the tree, then pop until the DUT reports empty (bounded).
  task automatic drain(input int budget);
    int k;
    for (int i = 0; i < LAT + 1; i++) nop_tick(1'b1);
    k = 0;
    while (out_valid && k < budget) begin
      nop_tick(1'b1);
      k++;
    end
    check("drain_empty", out_valid, 1'b0);
  endtask

  // Row i lane m = (i+1)<<m; the XOR of 1..8 is 8, so lane m = 8<<m after 5 cycles.
  task automatic directed_single(input string tag);
    logic [IN_W-1:0] rows;
    rows = '0;
    for (int i = 0; i < NUM_WR; i++)
      for (int m = 0; m < NUM_MUL; m++)
        rows[(i*NUM_MUL + m)*DW +: DW] = DW'(i + 1) << m;
    tick(32'h1234, 2'b01, rows, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) nop_tick(1'b1);
    check({tag, "_not_early"}, out_valid, 1'b0);
    nop_tick(1'b1);
    check({tag, "_valid_c5"}, out_valid, 1'b1);
    check({tag, "_key"}, out_key, 32'h1234);
    check({tag, "_opt"}, out_opt, 2'b01);
    for (int m = 0; m < NUM_MUL; m++)
      check($sformatf("%s_lane%0d", tag, m), out_data[m*DW +: DW], 64'h8 << m);
  endtask

  // Monitor: per-cycle status against the model, and head checks on every pop.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        check("out_valid", out_valid, model_cnt > 0);
        check("almost_full", almost_full, model_cnt >= AF_LEVEL);
        check("overflow", overflow, model_ovf);
        if (out_valid && out_ready) begin
          n_pops++;
          if (sb.size() == 0) begin
            check("unexpected_pop", 1'b1, 1'b0);
          end else begin
            e = sb.pop_front();
            check("head_key", out_key, e.key);
            check("head_opt", out_opt, e.opt);
            check("head_data", out_data, e.data);
`ifdef XOR_FP_MATCH_EN
            check("head_hit", out_hit, e.hit);
`endif
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] opts [5];
    int         pops0;
    opts[0] = 2'b01; opts[1] = 2'b00; opts[2] = 2'b10; opts[3] = 2'b00; opts[4] = 2'b11;

    // Reset and reset-state values.
    tick('0, 2'b00, '0, 1'b1, 1'b1);
    tick('0, 2'b00, '0, 1'b1, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_af", almost_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_key", out_key, '0);
    check("rst_opt", out_opt, '0);
    check("rst_data", out_data, '0);
    mon_en = 1;

    // Single op: latency and known reduction result.
    directed_single("single");
    drain(10);

    // Interleaved NOPs: exactly three results in order.
    pops0 = n_pops;
    for (int k = 0; k < 5; k++) tick($urandom, opts[k], rand_rows(), 1'b1, 1'b0);
    drain(20);
    check("nop_interleave_count", n_pops - pops0, 3);

    // Fill with out_ready low, then overflow on the 17th.
    for (int k = 0; k < DEPTH; k++) op_tick(1'b0);
    for (int k = 0; k < LAT + 1; k++) nop_tick(1'b0);
    check("full_af", almost_full, 1'b1);
    check("full_no_ovf", overflow, 1'b0);
    op_tick(1'b0);
    for (int k = 0; k < LAT + 1; k++) nop_tick(1'b0);
    check("ovf_set", overflow, 1'b1);
    drain(40);
    check("ovf_sticky", overflow, 1'b1);

    // Reset clears overflow; then full FIFO with simultaneous push and pop.
    tick('0, 2'b00, '0, 1'b1, 1'b1);
    check("rst2_ovf", overflow, 1'b0);
    for (int k = 0; k < 40; k++) op_tick(model_cnt == DEPTH);
    check("steady_full_valid", out_valid, 1'b1);
    check("steady_full_ovf", overflow, 1'b0);
    drain(60);

    // Reset with entries in the tree and in the FIFO.
    for (int k = 0; k < 8; k++) op_tick(1'b0);
    nop_tick(1'b0);
    tick('0, 2'b00, '0, 1'b0, 1'b1);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_af", almost_full, 1'b0);
    check("midrst_ovf", overflow, 1'b0);
    directed_single("postrst");
    drain(10);

`ifdef XOR_FP_MATCH_EN
    begin
      logic [IN_W-1:0] rows;
      rows = '0;
      rows[2*DW +: DW] = 64'hABCD;
      tick(32'h0000ABCD, 2'b01, rows, 1'b1, 1'b0);
      for (int k = 0; k < LAT; k++) nop_tick(1'b1);
      check("fp_hit", out_hit, 4'b0100);
      drain(10);
    end
`endif

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      tick($urandom, 2'($urandom_range(0, 3)), rand_rows(), $urandom_range(0, 9) < 6, 1'b0);
    end
    drain(60);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
